pll_underclock_ctrl: RTL

PLL_UNDERCLOCK_CTRL -- requirements
Module: pll_underclock_ctrl

---
 rtl/pll_underclock_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_underclock_ctrl.sv
// PLL underclock sequencer: synchronizes the mode request, then programs the PLL reconfig
// controller (MODE, K-fraction, START) with idle gaps. Define PLL_LOCK_WAIT_EN to wait for stable lock.
module pll_underclock_ctrl #(
  parameter logic [31:0] K_NATIVE    = 32'd3639383488,
  parameter logic [31:0] K_UNDER     = 32'd3262113561,
  parameter int unsigned GAP_CYCLES  = 3,
  parameter int unsigned LOCK_STABLE = 16
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock,
  input  logic        mgmt_waitrequest,
  input  logic        locked,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        core_hold,
  output logic        done,
  output logic        applied
);

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_GAP1, S_KFRAC, S_GAP2, S_START, S_LOCK, S_DONE
  } state_e;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic          target_q, target_d;
  logic          applied_q, applied_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          uc_meta_q, uc_sync_q, uc_stab_q;
  logic          req_valid;
  logic          lock_ok;

  // Two-flop synchronizer plus one extra sample so a request must be seen twice in a row.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      uc_meta_q <= 1'b0;
      uc_sync_q <= 1'b0;
      uc_stab_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
      uc_meta_q <= underclock;
      uc_sync_q <= uc_meta_q;
      uc_stab_q <= uc_sync_q;
    end
  end

  assign req_valid = (uc_sync_q == uc_stab_q) && (uc_sync_q != applied_q);

`ifdef PLL_LOCK_WAIT_EN
  localparam int LW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);

  logic          lk_meta_q, lk_sync_q;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      lk_meta_q  <= 1'b0;
      lk_sync_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lk_meta_q  <= locked;
      lk_sync_q  <= lk_meta_q;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Any low sample restarts the stability count; the count only runs while in LOCK.
  always_comb begin
    lock_cnt_d = '0;
    lock_ok    = 1'b0;
    if (state_q == S_LOCK && lk_sync_q) begin
      if (lock_cnt_q == LOCK_LAST) lock_ok = 1'b1;
      else                         lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = locked ^ (LOCK_STABLE == 0);
  assign lock_ok         = 1'b1;
`endif

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      target_q  <= 1'b0;
      applied_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    target_d  = target_q;
    applied_d = applied_q;
    gap_cnt_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_MODE;
          target_d = uc_sync_q;
        end
      end
      S_MODE:  if (!mgmt_waitrequest) state_d = S_GAP1;
      S_GAP1: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_KFRAC;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_KFRAC: if (!mgmt_waitrequest) state_d = S_GAP2;
      S_GAP2: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_START;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_START: if (!mgmt_waitrequest) state_d = S_LOCK;
      S_LOCK:  if (lock_ok) state_d = S_DONE;
      S_DONE: begin
        applied_d = target_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data depend only on state and the latched target, so they hold steady under stalls.
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    case (state_q)
      S_MODE:  mgmt_write = 1'b1;
      S_KFRAC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = target_q ? K_UNDER : K_NATIVE;
      end
      S_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign core_hold = busy;
  assign done      = (state_q == S_DONE);
  assign applied   = applied_q;

endmodule
